// File: rtl/div_req_arbiter_pkg.sv
// Shared definitions for the divider request arbiter: FSM state codes,
// default operand width and the divide-by-zero quotient pattern.
package div_req_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Wide enough for any practical XLEN; users slice the low XLEN bits.
    localparam logic [255:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_req_arbiter_rr_picker.sv
// Combinational round-robin selector: one-hot grant to the first active
// request found after the last granted index, wrapping around.
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]                         req,
    input  logic [$clog2((NREQ > 1) ? NREQ : 2)-1:0] last_idx,
    output logic [NREQ-1:0]                         gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last_idx) + off) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_req_arbiter.sv
// Arbitrates NREQ requesters onto one serial divider core, one operation
// in flight at a time, with divide-by-zero bypass and a WAIT timeout.
module div_req_arbiter
    import div_req_arbiter_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                     clk_i,
    input  logic                                     reset_ni,
    input  logic [NREQ-1:0]                          req_valid_i,
    output logic [NREQ-1:0]                          req_ready_o,
    input  logic [NREQ*XLEN-1:0]                     req_dividend_i,
    input  logic [NREQ*XLEN-1:0]                     req_divisor_i,
    output logic [NREQ-1:0]                          rsp_valid_o,
    input  logic [NREQ-1:0]                          rsp_ready_i,
    output logic [XLEN-1:0]                          rsp_quotient_o,
    output logic [XLEN-1:0]                          rsp_remainder_o,
    output logic                                     rsp_err_o,
    output logic                                     div_start_o,
    output logic [XLEN-1:0]                          div_dividend_o,
    output logic [XLEN-1:0]                          div_divisor_o,
    input  logic                                     div_fini_i,
    input  logic [XLEN-1:0]                          div_quotient_i,
    input  logic [XLEN-1:0]                          div_remainder_i,
    output logic                                     busy_o,
    output logic [$clog2((NREQ > 1) ? NREQ : 2)-1:0] owner_o
);

    localparam int OW = $clog2((NREQ > 1) ? NREQ : 2);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state;
    logic [OW-1:0]   rr_ptr;
    logic            granted_once;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last_idx;
    logic [OW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [XLEN-1:0] op_dividend;
    logic [XLEN-1:0] op_divisor;
    logic [XLEN-1:0] res_quotient;
    logic [XLEN-1:0] res_remainder;
    logic            res_err;
    logic [CW-1:0]   wait_cnt;
    logic            divisor_zero;
    logic            timeout_hit;

    // Before the first grant the search starts at index 0, so the lowest valid
    // requester wins after reset even though the pointer itself resets to 0.
    assign last_idx = granted_once ? rr_ptr : OW'(NREQ - 1);

    rr_picker #(.NREQ(NREQ)) u_rr_picker (
        .req      (req_valid_i),
        .last_idx (last_idx),
        .gnt      (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) gnt_idx = OW'(k);
        end
    end

    assign divisor_zero = (op_divisor == '0);
    // ISSUE plus the deciding WAIT cycle bring the response exactly
    // TIMEOUT_CYCLES cycles after the start pulse.
    assign timeout_hit  = (wait_cnt == CW'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            granted_once  <= 1'b0;
            owner         <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_err       <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        op_dividend  <= req_dividend_i[int'(gnt_idx)*XLEN +: XLEN];
                        op_divisor   <= req_divisor_i[int'(gnt_idx)*XLEN +: XLEN];
                        owner        <= gnt_idx;
                        rr_ptr       <= gnt_idx;
                        granted_once <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (divisor_zero) begin
                        res_quotient  <= DIV0_QUOTIENT[XLEN-1:0];
                        res_remainder <= op_dividend;
                        res_err       <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (div_fini_i) begin
                        res_quotient  <= div_quotient_i;
                        res_remainder <= div_remainder_i;
                        res_err       <= 1'b0;
                        state         <= ST_RESP;
                    end else if (timeout_hit) begin
                        res_quotient  <= '0;
                        res_remainder <= '0;
                        res_err       <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[owner]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is a pure function of IDLE and the picker, masked while in reset.
    assign req_ready_o = (reset_ni && (state == ST_IDLE)) ? gnt : '0;

    always_comb begin
        rsp_valid_o = '0;
        if (state == ST_RESP) rsp_valid_o[owner] = 1'b1;
    end

    assign rsp_quotient_o  = res_quotient;
    assign rsp_remainder_o = res_remainder;
    assign rsp_err_o       = res_err;
    assign div_start_o     = (state == ST_ISSUE) && !divisor_zero;
    assign div_dividend_o  = op_dividend;
    assign div_divisor_o   = op_divisor;
    assign busy_o          = (state != ST_IDLE);
    assign owner_o         = owner;

endmodule

// File: doc/div_req_arbiter.md
DIV_REQ_ARBITER -- requirements
Module: div_req_arbiter

Interface
REQ-001 Parameter XLEN, default 32: dividend, divisor, quotient and remainder width.
REQ-002 Parameter NREQ, default 2: number of requesters sharing one serial divider core.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: maximum cycles in WAIT before abort.
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low. Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  NREQ  per-requester operation request.
- req_ready_o  out  NREQ  per-requester accept, one-hot or zero.
- req_dividend_i  in  NREQ*XLEN  packed dividends; requester k at [k*XLEN +: XLEN].
- req_divisor_i  in  NREQ*XLEN  packed divisors, same packing.
- rsp_valid_o  out  NREQ  per-requester result valid, one-hot or zero.
- rsp_ready_i  in  NREQ  per-requester result accept.
- rsp_quotient_o  out  XLEN  shared result bus, quotient.
- rsp_remainder_o  out  XLEN  shared result bus, remainder.
- rsp_err_o  out  1  result flags divide-by-zero or timeout.
- div_start_o  out  1  one-cycle start pulse to the divider core.
- div_dividend_o  out  XLEN  operand to the core, held stable from start until fini.
- div_divisor_o  out  XLEN  operand to the core, held stable from start until fini.
- div_fini_i  in  1  core completion, level or pulse.
- div_quotient_i  in  XLEN  core quotient, valid while div_fini_i is high.
- div_remainder_i  in  XLEN  core remainder, valid while div_fini_i is high.
- busy_o  out  1  high in any state other than IDLE.
- owner_o  out  clog2(NREQ)  index of the current grant holder.

Function
REQ-005 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-006 IDLE: if any req_valid_i is high, select a requester by round-robin, starting the search at the index after the last granted one; assert req_ready_o for that index only, for one cycle; latch its operands, set owner_o, and go to ISSUE.
REQ-007 A request is accepted only in the cycle where req_valid_i[k] and req_ready_o[k] are both high; req_ready_o SHALL be 0 in all other states.
REQ-008 ISSUE, divisor nonzero: assert div_start_o for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-009 ISSUE, divisor zero: do not pulse div_start_o; result is quotient all-ones and remainder equal to the dividend, with rsp_err_o=1; go to RESP.
REQ-010 WAIT, div_fini_i high: capture div_quotient_i and div_remainder_i, set err=0, go to RESP.
REQ-011 WAIT, counter reaches TIMEOUT_CYCLES without fini: result is quotient 0 and remainder 0, with err=1; go to RESP.
REQ-012 Fini and timeout in the same cycle: fini wins.
REQ-013 div_fini_i outside WAIT SHALL be ignored.
REQ-014 RESP: rsp_valid_o[owner] is held high with the result stable. When rsp_ready_i[owner] is high, go to IDLE in the next cycle. rsp_ready_i of other indices is ignored.
REQ-015 Round-robin pointer updates only on grant. With NREQ=2 and both requesters continuously valid, grants SHALL alternate.
REQ-016 Latency from the accept cycle to the first rsp_valid_o cycle:
- divide-by-zero: 2 cycles;
- normal: 2 + core cycles until fini.
REQ-017 Throughput: no new grant until the response handshake completes; at most one operation in flight.
REQ-018 div_dividend_o and div_divisor_o SHALL hold the latched operands from ISSUE through WAIT, independent of any req_*_i changes.

Reset
REQ-019 While reset_ni is low, all state is cleared: FSM=IDLE, round-robin pointer=0, owner_o=0, counter=0, latched operands and results=0.
REQ-020 Reset outputs: req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, div_start_o=0, busy_o=0, rsp_quotient_o=0, rsp_remainder_o=0, div_dividend_o=0, div_divisor_o=0.
REQ-021 Reset asserted mid-operation abandons the operation with no response; the first grant after release goes to the lowest-index valid requester.

Structure
REQ-022 A shared package holds the FSM state enumeration, the XLEN default, and the divide-by-zero quotient constant (all-ones).
REQ-023 One sub-module, rr_picker: combinational NREQ-wide round-robin selector; inputs are the request vector and the last-grant index, output is the one-hot grant.

Verification
REQ-024 The bench SHALL cover:
- req0: 100/25 -> one div_start_o pulse; core fini -> rsp_valid_o[0], quotient 4, remainder 0, err 0.
- req1: 7/0 -> no div_start_o; rsp_valid_o[1] 2 cycles after accept; quotient FFFFFFFF, remainder 7, err 1.
- req0 and req1 held valid continuously -> grant order 0,1,0,1; never two operations in flight.
- core never asserts fini, TIMEOUT_CYCLES=64 -> rsp_valid_o 64 cycles after start; err 1, quotient 0.
- reset_ni low during WAIT -> all outputs 0 immediately; after release, req1 alone valid -> granted.
- rsp_ready_i held low for 10 cycles in RESP -> result stable, busy_o=1, the other requester not granted.
